// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad_io controller-port block.
// JOYPAD_FOUR_SCORE_EN widens the shift chains to 24 bits (Four Score adapter).
package joypad_pkg;

  // Bit position of each button inside a pad byte (shift order).
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_e;

  // Register offsets from the base address.
  localparam int unsigned PORT0_OFS = 0;
  localparam int unsigned PORT1_OFS = 1;

  // Four Score signature bytes, shifted out after both pads of a port.
  localparam logic [7:0] SIG0 = 8'h10;
  localparam logic [7:0] SIG1 = 8'h20;

`ifdef JOYPAD_FOUR_SCORE_EN
  localparam int unsigned SHIFT_W = 24;
`else
  localparam int unsigned SHIFT_W = 8;
`endif

endpackage

// File: rtl/joypad_io_if.sv
// System (clock/reset) interface and CPU bus responder interface for joypad_io.
interface sys_if;
  logic clk;
  logic n_reset;

  modport master (output clk, output n_reset);
  modport slave  (input clk, input n_reset);
endinterface

interface joypad_io_if #(
  parameter int ADDR_N = 16,
  parameter int DATA_N = 8
);
  logic [ADDR_N-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_N-1:0] in;
  logic [DATA_N-1:0] out;
  logic              hit;

  modport master (output addr, output rd, output wr, output in, input out, input hit);
  modport slave  (input addr, input rd, input wr, input in, output out, output hit);
endinterface

// File: rtl/joypad_shift.sv
// Serial button shift register for one controller port; shifts LSB-first and
// back-fills ones so an exhausted chain reads 1 forever.
module joypad_shift
  import joypad_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  output logic         q0
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Next-state: reload while strobed, otherwise shift once per read access.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      shreg_d = {1'b1, shreg_q[W-1:1]};
    end
  end

  // State register; reset fills with ones (reads as "not pressed").
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shreg_q <= '1;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q0 = shreg_q[0];

endmodule

// File: rtl/joypad_io.sv
// Controller-port responder at BASE_ADDR/BASE_ADDR+1: strobe latch, per-port
// shift registers, address decode and tri-stated read data.
// Optional macro JOYPAD_FOUR_SCORE_EN adds pad2/pad3 and 24-bit chains.
module joypad_io
  import joypad_pkg::*;
#(
  parameter int              ADDR_N    = 16,
  parameter int              DATA_N    = 8,
  parameter logic [ADDR_N-1:0] BASE_ADDR = 16'h4016,
  parameter logic [DATA_N-1:0] OPEN_BUS  = 8'h40
) (
  sys_if.slave       sys,
  joypad_io_if.slave bus,
  input  logic [7:0] pad0_buttons,
  input  logic [7:0] pad1_buttons,
`ifdef JOYPAD_FOUR_SCORE_EN
  input  logic [7:0] pad2_buttons,
  input  logic [7:0] pad3_buttons,
`endif
  output logic       pad_strobe
);

  localparam logic [ADDR_N-1:0] PORT0_ADDR = BASE_ADDR + ADDR_N'(PORT0_OFS);
  localparam logic [ADDR_N-1:0] PORT1_ADDR = BASE_ADDR + ADDR_N'(PORT1_OFS);

  logic strobe_q, strobe_d;
  logic rd_q, rd_d;
  logic sel0, sel1, hit, wr_acc, rd_acc;
  logic shift0, shift1, q0_0, q0_1, rd_bit;
  logic [SHIFT_W-1:0] load0, load1;
  logic unused_in;

  // Only bit 0 of the written byte reaches the strobe latch.
  assign unused_in = ^bus.in[DATA_N-1:1];

  // Snapshot contents each port presents while the strobe is high.
`ifdef JOYPAD_FOUR_SCORE_EN
  assign load0 = {SIG0, pad2_buttons, pad0_buttons};
  assign load1 = {SIG1, pad3_buttons, pad1_buttons};
`else
  assign load0 = pad0_buttons;
  assign load1 = pad1_buttons;
`endif

  // Decode, access qualification, shift enables and read-bit selection.
  always_comb begin
    sel0     = (bus.addr == PORT0_ADDR);
    sel1     = (bus.addr == PORT1_ADDR);
    // $4017 writes belong to the APU frame counter, so only reads hit there.
    hit      = (sel0 && (bus.rd || bus.wr)) || (sel1 && bus.rd);
    wr_acc   = sel0 && bus.wr;
    // A simultaneous write takes the cycle: no read data, no shift.
    rd_acc   = hit && bus.rd && !bus.wr;
    strobe_d = wr_acc ? bus.in[0] : strobe_q;
    rd_d     = bus.rd;
    // Shift only on the first cycle of a read so long reads advance once.
    shift0   = rd_acc && sel0 && !rd_q && !strobe_q;
    shift1   = rd_acc && sel1 && !rd_q && !strobe_q;
    // While strobed the chain is continuously reloading; return the live A bit.
    rd_bit   = 1'b1;
    if (sel0) begin
      rd_bit = strobe_q ? pad0_buttons[BTN_A] : q0_0;
    end else begin
      rd_bit = strobe_q ? pad1_buttons[BTN_A] : q0_1;
    end
  end

  // Strobe latch and registered read strobe.
  always_ff @(posedge sys.clk) begin
    if (!sys.n_reset) begin
      strobe_q <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      rd_q     <= rd_d;
    end
  end

  joypad_shift #(.W(SHIFT_W)) u_shift0 (
    .clk       (sys.clk),
    .n_reset   (sys.n_reset),
    .load      (strobe_q),
    .load_data (load0),
    .shift_en  (shift0),
    .q0        (q0_0)
  );

  joypad_shift #(.W(SHIFT_W)) u_shift1 (
    .clk       (sys.clk),
    .n_reset   (sys.n_reset),
    .load      (strobe_q),
    .load_data (load1),
    .shift_en  (shift1),
    .q0        (q0_1)
  );

  assign bus.hit    = hit;
  assign bus.out    = rd_acc ? {OPEN_BUS[DATA_N-1:1], rd_bit} : 'bz;
  assign pad_strobe = strobe_q;

endmodule

// File: doc/joypad_io.md
Name: joypad_io

Overview:
- Memory-mapped responder on the CPU system bus for the two standard controller ports at $4016/$4017.
- It is the responder end of the address path: the CPU places addresses on sysbus.addr, and this block decodes them and answers reads and writes.
- Holds the strobe latch and one serial shift register per port.
- Reads return one button bit per access; a read advances that port's shift register.

Parameters:
- ADDR_N, 16, address bus width.
- DATA_N, 8, data bus width.
- BASE_ADDR, 16'h4016, address of port 0; port 1 is at BASE_ADDR+1.
- OPEN_BUS, 8'h40, value driven on data bits [DATA_N-1:1] during reads; bit 0 comes from the shifter.

Ports:
- sys.clk  in  1  system clock (sys_if).
- sys.n_reset  in  1  reset, synchronous, active-low (sys_if).
- addr  in  ADDR_N  address, taken from sysbus.addr.
- rd  in  1  read strobe for the current bus cycle.
- wr  in  1  write strobe for the current bus cycle.
- in  in  DATA_N  write data.
- out  out  DATA_N  read data, tri-stated ('bz) when not driving.
- hit  out  1  combinational address-decode hit.
- pad0_buttons  in  8  live buttons, port 0; bit order A,B,Select,Start,Up,Down,Left,Right = bit0..7; 1 = pressed.
- pad1_buttons  in  8  live buttons, port 1.
- pad_strobe  out  1  strobe latch, driven to the connectors.

Behaviour:
- Reset (sync, ~sys.n_reset sampled at posedge sys.clk):
  - strobe=0, both shift registers all-ones, rd_q=0.
  - out='bz, pad_strobe=0.
- Decode:
  - hit=1 when (addr==BASE_ADDR and (rd or wr)), or (addr==BASE_ADDR+1 and rd).
  - A write to BASE_ADDR+1 is ignored (APU frame-counter space) and gives hit=0.
- Write to BASE_ADDR: strobe <= in[0] on the next clock edge. Other data bits are ignored.
- Strobe high: every clock, both shift registers reload from the live pad*_buttons. Reads return the live A bit and do not shift.
- Strobe falling (1->0 write): the registers keep the values loaded in the last strobe-high cycle, which is the snapshot.
- Read, port p:
  - Combinational, same cycle: out = {OPEN_BUS[DATA_N-1:1], shreg_p[0]}.
  - Shift: at the clock edge ending a read access (rd && hit && ~rd_q), when strobe==0, shreg_p <= {1'b1, shreg_p[W-1:1]}.
  - rd_q is rd registered, so a multi-cycle rd shifts exactly once.
- Exhaustion: after W reads without a new strobe, bit 0 returns 1 indefinitely.
- rd and wr both asserted: the write wins, there is no shift, and out stays 'bz.
- A read of one port never shifts the other port.
- A reset during an access overrides everything; the read data in that cycle still follows the combinational rule.

Optional Feature:
- Macro: JOYPAD_FOUR_SCORE_EN.
- With the macro defined:
  - Extra ports pad2_buttons and pad3_buttons (8 bits each).
  - Shift registers are 24 bits.
  - Port 0 loads {SIG0, pad2, pad0}; port 1 loads {SIG1, pad3, pad1}.
  - SIG0=8'h10 and SIG1=8'h20, so the read order is pad, second pad, signature LSB-first.
  - Exhaustion (all-ones fill) starts after 24 reads.
- Without the macro: 8-bit registers, no extra ports.

Decomposition:
- joypad_pkg holds:
  - Button bit-index enum.
  - Register offsets (PORT0_OFS=0, PORT1_OFS=1).
  - SIG0/SIG1 constants.
  - Shift width localparam (8 or 24, selected by JOYPAD_FOUR_SCORE_EN).
- One sub-module, joypad_shift (parameter W), instantiated per port. Inputs: load, load_data, shift_en. Output: q0.
- Top level holds decode, the strobe latch, rd_q and the out mux.

Test Plan:
- Reset: release reset with buttons=8'hA5 -> pad_strobe=0, out='bz; one read of $4016 returns 8'h41.
- Latch and read: pad0=8'b1000_0101; write $4016=1 then 0; set pad0=0; 8 single-cycle reads of $4016 -> bit0 sequence 1,0,1,0,0,0,0,1, each byte OPEN_BUS|bit; reads 9 and 10 return 8'h41.
- Strobe held: strobe=1 with pad1 toggling A each cycle -> every $4017 read follows live A; no shift after strobe drops without a new snapshot.
- Port independence / multi-cycle: rd held 3 cycles on $4017 -> one shift only; $4016 sequence unaffected.
- Priority: rd and wr both asserted to $4016 with in=1 -> strobe=1, no shift, out='bz; a write to $4017 -> hit=0, state unchanged.
- Four Score (macro on): pad0=8'h01, pad2=8'h02 -> 24 reads give 1,0×7, 0,1,0×6, then 0,0,0,0,1,0,0,0; read 25 returns 1.
